// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: funct3 encodings, shared-ALU op codes and sequencer states for muldiv_seq
package muldiv_seq_pkg;
  localparam logic [2:0] MD_MUL = 3'b000, MD_DIV = 3'b100, MD_DIVU = 3'b101, MD_REM = 3'b110, MD_REMU = 3'b111;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLTU = 4'd3;
  typedef enum logic [2:0] {IDLE, MUL_IT, DIV_CMP, DIV_SUB, FINISH} md_state_t;
endpackage

// File: rtl/md_abs.sv
// md_abs: magnitude of val (two's-complement when sgn) -> mag, neg flags a negative signed input
module md_abs #(parameter int W = 32) (
  input  logic [W-1:0] val,
  input  logic         sgn,
  output logic [W-1:0] mag,
  output logic         neg
);
  assign neg = sgn && val[W-1];
  assign mag = neg ? ~val + W'(1) : val;
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M mul/div over a shared ALU; start/funct3/rs1/rs2 in, busy/done/result/illegal out, alu_op/alu_inA/alu_inB out, alu_out in
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         kill,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rs1,
  input  logic [N-1:0] rs2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         illegal,
  output logic [3:0]   alu_op,
  output logic [N-1:0] alu_inA,
  output logic [N-1:0] alu_inB,
  input  logic [N-1:0] alu_out
);
  md_state_t state, nxt;
  logic [N-1:0] dvd, rem, dsr, a_mag, b_mag, sub_rem, q_fix, r_fix;
  logic [CNT_W-1:0] cnt;
  logic a_neg, b_neg, sdiv, is_mul, legal, div0, ovf, accept;
  logic sel_rem, ill, qs, rs, lt, c32, take, last;
  md_abs #(.W(N)) u_abs_a (.val(rs1), .sgn(sdiv), .mag(a_mag), .neg(a_neg));
  md_abs #(.W(N)) u_abs_b (.val(rs2), .sgn(sdiv), .mag(b_mag), .neg(b_neg));
  assign is_mul  = funct3 == MD_MUL;
  assign legal   = funct3 inside {MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  assign sdiv    = funct3 == MD_DIV || funct3 == MD_REM;
  assign div0    = !is_mul && rs2 == '0;
  assign ovf     = sdiv && rs1 == {1'b1, {(N-1){1'b0}}} && &rs2;
  assign accept  = start && !kill;
  assign take    = c32 || !lt;
  assign sub_rem = take ? alu_out : alu_inA;
  assign q_fix   = qs ? ~dvd + N'(1) : dvd;
  assign r_fix   = rs ? ~rem + N'(1) : rem;
  assign last    = &cnt;
  always_ff @(posedge clock)
    state <= !reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = (!legal || div0 || ovf) ? FINISH : is_mul ? MUL_IT : DIV_CMP;
      MUL_IT:  if (last) nxt = FINISH;
      DIV_CMP: nxt = DIV_SUB;
      DIV_SUB: nxt = last ? FINISH : DIV_CMP;
      default: nxt = IDLE;
    endcase
    if (kill && state != IDLE) nxt = IDLE;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      result  <= '0;
      alu_op  <= ALU_ADD;
      alu_inA <= '0;
      alu_inB <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (kill && state != IDLE) begin
        busy    <= 1'b0;
        alu_op  <= ALU_ADD;
        alu_inA <= '0;
        alu_inB <= '0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            busy    <= 1'b1;
            sel_rem <= funct3[1];
            ill     <= !legal;
            cnt     <= '0;
            qs      <= 1'b0;
            rs      <= 1'b0;
            if (!legal) begin
              dvd <= '0;
              rem <= '0;
            end else if (is_mul) begin
              dvd     <= '0;
              rem     <= rs2;
              dsr     <= rs1;
              alu_inA <= '0;
              alu_inB <= rs2[0] ? rs1 : '0;
            end else if (div0) begin
              dvd <= '1;
              rem <= rs1;
            end else if (ovf) begin
              dvd <= {1'b1, {(N-1){1'b0}}};
              rem <= '0;
            end else begin
              dvd     <= a_mag;
              rem     <= '0;
              dsr     <= b_mag;
              qs      <= a_neg ^ b_neg;
              rs      <= a_neg;
              alu_op  <= ALU_SLTU;
              alu_inA <= {{(N-1){1'b0}}, a_mag[N-1]};
              alu_inB <= b_mag;
            end
          end
          MUL_IT: begin
            dvd     <= alu_out;
            dsr     <= dsr << 1;
            rem     <= rem >> 1;
            cnt     <= cnt + CNT_W'(1);
            alu_inA <= alu_out;
            alu_inB <= rem[1] ? dsr << 1 : '0;
          end
          DIV_CMP: begin
            lt     <= alu_out[0];
            c32    <= rem[N-1];
            alu_op <= ALU_SUB;
          end
          DIV_SUB: begin
            rem     <= sub_rem;
            dvd     <= {dvd[N-2:0], take};
            cnt     <= cnt + CNT_W'(1);
            alu_op  <= ALU_SLTU;
            alu_inA <= {sub_rem[N-2:0], dvd[N-2]};
          end
          default: begin
            busy    <= 1'b0;
            done    <= 1'b1;
            illegal <= ill;
            result  <= sel_rem ? r_fix : q_fix;
            alu_op  <= ALU_ADD;
            alu_inA <= '0;
            alu_inB <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed scoreboard bench for muldiv_seq with a behavioural shared ALU
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;
  logic clock = 1'b0, reset, start, kill, busy, done, illegal;
  logic [2:0] funct3;
  logic [31:0] rs1, rs2, result, alu_inA, alu_inB, alu_out;
  logic [3:0] alu_op;
  int n_chk = 0, n_err = 0, cyc = 0, done_cnt = 0, d0;
  logic [31:0] prev;
  logic [31:0] exp_q[$];
  logic ill_q[$];
  int lat_q[$];
  muldiv_seq dut (
    .clock(clock), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result), .illegal(illegal),
    .alu_op(alu_op), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_out(alu_out)
  );
  always #5 clock = ~clock;
  always_comb
    alu_out = alu_op == ALU_ADD ? alu_inA + alu_inB :
              alu_op == ALU_SUB ? alu_inA - alu_inB :
              alu_op == ALU_SLTU ? {31'b0, alu_inA < alu_inB} : '0;
  always @(posedge clock) if (done) done_cnt <= done_cnt + 1;
  function automatic logic is_legal(input logic [2:0] f);
    return f inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
  endfunction
  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic ov;
    ov = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (f)
      3'b000:  return a * b;
      3'b100:  return b == 0 ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'b101:  return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'b110:  return b == 0 ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b));
      3'b111:  return b == 0 ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!is_legal(f)) return 2;
    if (f == 3'b000) return 34;
    if (b == 0 || ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 66;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    exp_q.push_back(golden(f, a, b));
    ill_q.push_back(!is_legal(f));
    lat_q.push_back(exp_lat(f, a, b));
    @(negedge clock);
    start = 1'b0; cyc = 1;
    rs1 = $urandom; rs2 = $urandom;
    chk("busy_c1", {31'b0, busy}, 32'd1);
  endtask
  task automatic wait_done();
    int lat;
    logic [31:0] e;
    logic il;
    lat = lat_q.pop_front(); e = exp_q.pop_front(); il = ill_q.pop_front();
    while (!done && cyc < 200) begin
      tick();
      if (cyc == lat - 1) chk("busy_last", {31'b0, busy}, 32'd1);
    end
    chk("latency", cyc, lat);
    chk("done", {31'b0, done}, 32'd1);
    chk("result", result, e);
    chk("illegal", {31'b0, illegal}, {31'b0, il});
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    tick();
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("result_hold", result, e);
  endtask
  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b);
    wait_done();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'b0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
    chk("rst_alu_inA", alu_inA, 32'd0);
    chk("rst_alu_inB", alu_inB, 32'd0);
    reset = 1'b1;
    run(MD_MUL, 32'd7, 32'hFFFF_FFFD);
    run(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run(MD_REM, 32'hFFFF_FFF9, 32'd2);
    run(MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
    run(MD_REMU, 32'hFFFF_FFFF, 32'h8000_0001);
    run(MD_DIV, 32'd5, 32'd0);
    run(MD_REM, 32'd5, 32'd0);
    run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run(3'b010, 32'd9, 32'd3);
    run(MD_REM, 32'd100, 32'hFFFF_FFF9);
    issue(MD_DIV, 32'd1000, 32'd7);
    d0 = done_cnt;
    repeat (9) tick();
    funct3 = MD_MUL; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    repeat (80) tick();
    chk("single_done", done_cnt - d0, 32'd1);
    prev = result;
    @(negedge clock);
    funct3 = MD_DIV; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0; cyc = 1;
    d0 = done_cnt;
    repeat (18) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    repeat (80) tick();
    chk("kill_no_done", done_cnt - d0, 32'd0);
    chk("kill_result", result, prev);
    @(negedge clock);
    funct3 = MD_MUL; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; kill = 1'b1;
    @(negedge clock);
    start = 1'b0; kill = 1'b0;
    chk("kill_beats_start", {31'b0, busy}, 32'd0);
    repeat (40) tick();
    chk("kill_start_no_done", done_cnt - d0, 32'd0);
    @(negedge clock);
    funct3 = MD_MUL; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
    @(negedge clock);
    start = 1'b0; cyc = 1;
    repeat (9) tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_alu_op", {28'b0, alu_op}, {28'b0, ALU_ADD});
    chk("mid_rst_alu_inA", alu_inA, 32'd0);
    chk("mid_rst_alu_inB", alu_inB, 32'd0);
    reset = 1'b1;
    run(MD_MUL, 32'd3, 32'd4);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] f;
      f = 3'($urandom_range(0, 7));
      run(f, $urandom, (i == 5) ? 32'($urandom_range(1, 20)) : $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer for the execute stage.
- It does not contain its own adder. It sequences a shared 32-bit ALU instance through its alu_op/alu_inA/alu_inB/alu_out ports, one ALU operation per cycle.
- Accepts one request at a time: start pulse → busy → one-cycle done pulse with the result.
- The pipeline stalls on busy.

Parameters:
- N, 32, datapath width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 N).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request valid; sampled only in IDLE.
- kill  in  1  abort the current operation (pipeline flush).
- funct3  in  3  RV32M funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  32  operand A (multiplicand or dividend).
- rs2  in  32  operand B (multiplier or divisor).
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse; result valid this cycle only.
- result  out  32  operation result; holds its last value otherwise.
- illegal  out  1  pulses with done when funct3 is 001, 010 or 011.
- alu_op  out  4  ALU operation code: `ADD, `SUB, `SLTU.
- alu_inA  out  32  ALU operand A.
- alu_inB  out  32  ALU operand B.
- alu_out  in  32  combinational ALU result.

Behaviour:
- Reset (reset==0 at an edge), from any state including mid-operation:
  - state → IDLE.
  - busy, done, illegal, result → 0.
  - alu_op → `ADD; alu_inA, alu_inB → 0.
- States: IDLE, MUL_IT, DIV_CMP, DIV_SUB, FINISH.
- IDLE:
  - Drives ADD 0,0.
  - On start at edge E0: latch funct3 and operands, set busy, clear counter.
  - Next state by case:
    - Illegal funct3 → FINISH, result 0, illegal=1.
    - DIV/DIVU/REM/REMU with rs2==0 → FINISH: quotient 0xFFFFFFFF, remainder rs1.
    - DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF → FINISH: quotient 0x80000000, remainder 0.
    - MUL → MUL_IT.
    - Otherwise → DIV_CMP.
  - Signed DIV/REM: latch |rs1| and |rs2| using internal two's-complement logic (not the ALU). Record the quotient sign (rs1[31]^rs2[31]) and the remainder sign (rs1[31]).
- MUL_IT, 32 cycles (shift-add, unsigned; low 32 bits are sign-independent):
  - alu_op=`ADD, alu_inA=acc, alu_inB = mplier[0] ? mcand : 0.
  - Each cycle: acc←alu_out, mcand←mcand<<1, mplier←mplier>>1.
  - After counter reaches 31 → FINISH.
- DIV_CMP (restoring division):
  - Form 33-bit rshift={rem,dvd[31]}.
  - alu_op=`SLTU, alu_inA=rshift[31:0], alu_inB=divisor.
  - Latch the compare result and rshift[32] → DIV_SUB.
- DIV_SUB:
  - alu_op=`SUB, alu_inA=rshift[31:0], alu_inB=divisor.
  - If rshift[32]==1 or SLTU result==0: rem←alu_out, quotient bit=1.
  - Else: rem←rshift[31:0], quotient bit=0.
  - dvd shifts left, taking in the quotient bit.
  - After 32 CMP/SUB pairs → FINISH, else → DIV_CMP.
- FINISH:
  - Apply the sign fixups internally: negate the quotient if its sign flag is set; negate the remainder if rs1 was negative.
  - Select quotient or remainder by funct3[1]; drive result, done=1, busy=0; → IDLE.
- Latency from the start edge E0 to the done cycle:
  - MUL: 34 cycles.
  - DIV/DIVU/REM/REMU: 66 cycles.
  - Special cases and illegal: 2 cycles.
- start while busy: ignored, no queuing.
- start in the FINISH cycle: ignored. A new start is accepted in IDLE on the following cycle at the earliest.
- kill, from any non-IDLE state: → IDLE next edge, busy=0, no done pulse, result unchanged. kill in IDLE has no effect; kill wins over start in the same cycle.
- alu_* outputs are registered. Operands and op are stable for the whole cycle the ALU result is consumed.

Decomposition:
- constants.vh:
  - `MD_MUL, `MD_DIV, `MD_DIVU, `MD_REM, `MD_REMU funct3 encodings.
  - MD state encodings.
  - Reuse the existing `ADD, `SUB, `SLTU ALU codes.
- One combinational sub-module md_abs (input 32-bit value and a signed flag; output magnitude and a negative flag). Used both for operand conditioning and for the FINISH negation.

Test Plan:
- MUL: rs1=7, rs2=0xFFFFFFFD → done exactly 34 cycles after start, result 0xFFFFFFEB; busy high cycles 1–33.
- DIV rs1=0xFFFFFFF9 (−7), rs2=2 → result 0xFFFFFFFD at +66. REM with the same operands → 0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0x80000001 → quotient 1; REMU with the same operands → 0x7FFFFFFE (exercises the rshift[32] carry path).
- Divide-by-zero: DIV 5/0 → 0xFFFFFFFF at +2; REM 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
- Illegal funct3=010 → done+illegal at +2, result 0. A second start during a running DIV is ignored and the original result is unchanged.
- kill at cycle 20 of a DIV → IDLE, no done. Then reset low at cycle 10 of a MUL → all outputs 0 next edge. A new MUL 3×4 afterwards → 12 at +34.
